// File: rtl/vx_mshr_pkg.sv
// Shared types for the MSHR queue: the per-entry lifecycle state and helpers.
package vx_mshr_pkg;

    // Entry lifecycle: FREE -> WAIT (allocated, miss outstanding)
    // -> READY (line filled) -> ISSUED (handed to replay) -> FREE (released).
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        WAIT   = 2'd1,
        READY  = 2'd2,
        ISSUED = 2'd3
    } mshr_state_e;

    // An entry counts toward occupancy and address matching unless it is FREE.
    function automatic logic is_busy(input mshr_state_e state);
        return state != FREE;
    endfunction

endpackage

// File: rtl/vx_mshr_queue_lzc.sv
// Lowest-index priority encoder: reports the index of the lowest set bit
// and whether any bit is set.
module VX_lzc #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         valid_out
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        data_out = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (data_in[i]) begin
                data_out = W'(i);
            end
        end
        valid_out = |data_in;
    end

endmodule

// File: rtl/vx_mshr_queue.sv
// Miss-status holding queue for one cache bank. Each entry walks
// FREE -> WAIT -> READY -> ISSUED -> FREE; a fill wakes every waiting entry
// on the same line, so secondary misses need no separate replay lookup.
module vx_mshr_queue
    import vx_mshr_pkg::*;
#(
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int DATA_WIDTH      = 64,
    parameter int MSHR_SIZE       = 8,
    parameter int ALM_FULL_THRESH = MSHR_SIZE - 1,
    parameter int ID_W            = $clog2(MSHR_SIZE),
    parameter int CNT_W           = $clog2(MSHR_SIZE + 1)
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       allocate_valid,
    output logic                       allocate_ready,
    input  logic [LINE_ADDR_WIDTH-1:0] allocate_addr,
    input  logic [DATA_WIDTH-1:0]      allocate_data,
    input  logic                       allocate_prefetch,
    output logic [ID_W-1:0]            allocate_id,
    output logic                       allocate_pending,

    input  logic                       fill_valid,
    input  logic [ID_W-1:0]            fill_id,
    output logic [LINE_ADDR_WIDTH-1:0] fill_addr,

    output logic                       dequeue_valid,
    input  logic                       dequeue_ready,
    output logic [ID_W-1:0]            dequeue_id,
    output logic [LINE_ADDR_WIDTH-1:0] dequeue_addr,
    output logic [DATA_WIDTH-1:0]      dequeue_data,
    output logic                       dequeue_prefetch,

    input  logic                       release_valid,
    input  logic [ID_W-1:0]            release_id,

    output logic [CNT_W-1:0]           count,
    output logic                       almost_full
);

    mshr_state_e                state_q [MSHR_SIZE];
    mshr_state_e                state_d [MSHR_SIZE];
    logic [LINE_ADDR_WIDTH-1:0] addr_q  [MSHR_SIZE];
    logic [DATA_WIDTH-1:0]      data_q  [MSHR_SIZE];
    logic [MSHR_SIZE-1:0]       prefetch_q;
    logic [CNT_W-1:0]           count_q;

    logic [MSHR_SIZE-1:0] free_mask;
    logic [MSHR_SIZE-1:0] ready_mask;
    logic [MSHR_SIZE-1:0] pending_mask;
    logic [ID_W-1:0]      free_id;
    logic [ID_W-1:0]      ready_id;
    logic                 free_any;
    logic                 ready_any;

    logic alloc_fire;
    logic dequeue_fire;
    logic release_ok;
    logic alloc_hits_fill;

    // Per-entry status vectors for the two encoders and the secondary-miss match.
    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        free_mask    = '0;
        ready_mask   = '0;
        pending_mask = '0;
        for (int i = 0; i < MSHR_SIZE; i++) begin
            free_mask[i]    = (state_q[i] == FREE);
            ready_mask[i]   = (state_q[i] == READY);
            pending_mask[i] = is_busy(state_q[i]) && (addr_q[i] == allocate_addr);
        end
    end

    VX_lzc #(.N(MSHR_SIZE), .W(ID_W)) free_sel (
        .data_in   (free_mask),
        .data_out  (free_id),
        .valid_out (free_any)
    );

    VX_lzc #(.N(MSHR_SIZE), .W(ID_W)) ready_sel (
        .data_in   (ready_mask),
        .data_out  (ready_id),
        .valid_out (ready_any)
    );

    assign allocate_ready   = free_any;
    assign allocate_id      = free_id;
    assign allocate_pending = |pending_mask;
    assign fill_addr        = addr_q[fill_id];

    assign dequeue_valid    = ready_any;
    assign dequeue_id       = ready_id;
    assign dequeue_addr     = addr_q[ready_id];
    assign dequeue_data     = data_q[ready_id];
    assign dequeue_prefetch = prefetch_q[ready_id];

    assign count       = count_q;
    assign almost_full = (32'(count_q) >= ALM_FULL_THRESH);

    assign alloc_fire      = allocate_valid && free_any;
    assign dequeue_fire    = ready_any && dequeue_ready;
    assign release_ok      = release_valid && (state_q[release_id] == ISSUED);
    assign alloc_hits_fill = fill_valid && (allocate_addr == fill_addr);

    // Next entry states, every decision taken on pre-edge state. The four
    // updates touch disjoint source states, so their order never matters.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < MSHR_SIZE; i++) begin
            if (fill_valid && state_q[i] == WAIT && addr_q[i] == fill_addr) begin
                state_d[i] = READY;
            end
        end
        if (dequeue_fire) begin
            state_d[ready_id] = ISSUED;
        end
        if (release_ok) begin
            state_d[release_id] = FREE;
        end
        // A new entry for the line being filled this cycle must not miss its wakeup.
        if (alloc_fire) begin
            state_d[free_id] = alloc_hits_fill ? READY : WAIT;
        end
    end

    // Entry states and occupancy counter.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSHR_SIZE; i++) begin
                state_q[i] <= FREE;
            end
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(release_ok);
        end
    end

    // Entry payload, written on allocate and read at the dequeue selection.
    // NOTE: the payload array is deliberately not reset; entry state alone decides validity.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            addr_q[free_id]     <= allocate_addr;
            data_q[free_id]     <= allocate_data;
            prefetch_q[free_id] <= allocate_prefetch;
        end
    end

`ifndef SYNTHESIS
    // Protocol checks: fills target waiting entries, releases target issued entries.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_valid) begin
                assert (state_q[fill_id] == WAIT);
            end
            if (release_valid) begin
                assert (state_q[release_id] == ISSUED);
            end
        end
    end
`endif

endmodule

// File: doc/vx_mshr_queue.md
# vx_mshr_queue

Parametrised miss-status holding queue for one cache bank, successor to the bank's miss reservation station. It tracks outstanding misses per entry with an explicit four-state lifecycle, so a fill wakes every entry waiting on the same line without a separate replay lookup. It also reports secondary misses at allocation, carries a per-entry prefetch flag, and exposes occupancy and almost-full for back-pressure. It sits between the bank's miss path (allocate), the memory response path (fill) and the bank replay pipeline (dequeue/release).

## Interface
- LINE_ADDR_WIDTH, 26, line address bits.
- DATA_WIDTH, 64, per-entry payload (core tag, word offset, etc.).
- MSHR_SIZE, 8, entries; ≥2.
- ALM_FULL_THRESH, MSHR_SIZE-1, almost_full asserts when count ≥ this value.
- ID_W, $clog2(MSHR_SIZE), entry id width (derived).
- CNT_W, $clog2(MSHR_SIZE+1), occupancy width (derived).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- allocate_valid / allocate_ready  in/out  1  allocate handshake.
- allocate_addr  in  LINE_ADDR_WIDTH  line address.
- allocate_data  in  DATA_WIDTH  payload.
- allocate_prefetch  in  1  entry is a prefetch.
- allocate_id  out  ID_W  id assigned on fire.
- allocate_pending  out  1  a non-FREE entry already holds allocate_addr (secondary miss; caller suppresses the memory request).
- fill_valid  in  1  memory response.
- fill_id  in  ID_W  primary entry id of the response.
- fill_addr  out  LINE_ADDR_WIDTH  address of entry fill_id.
- dequeue_valid / dequeue_ready  out/in  1  replay handshake.
- dequeue_id  out  ID_W  entry id.
- dequeue_addr  out  LINE_ADDR_WIDTH  entry address.
- dequeue_data  out  DATA_WIDTH  entry payload.
- dequeue_prefetch  out  1  entry prefetch flag.
- release_valid  in  1  free an entry.
- release_id  in  ID_W  entry id to free.
- count  out  CNT_W  number of non-FREE entries.
- almost_full  out  1  count ≥ ALM_FULL_THRESH.

## Operation
- Per-entry state is one of FREE, WAIT, READY or ISSUED. Reset puts every entry in FREE.
- Allocate fire (valid & ready):
  - the entry moves FREE→WAIT at allocate_id;
  - addr, data and prefetch are stored;
  - allocate_id is the lowest-index FREE entry in current state;
  - allocate_ready = any entry FREE.
- allocate_pending is combinational. It compares allocate_addr against all non-FREE entries, using current state only.
- Fill:
  - every WAIT entry whose addr equals addr[fill_id] moves to READY;
  - fill_id itself must be WAIT; otherwise a runtime assertion fires.
- Dequeue:
  - dequeue_valid = any entry READY;
  - the selected entry is the lowest-index READY entry;
  - on fire, that entry moves READY→ISSUED.
- Release moves release_id ISSUED→FREE. Release of a non-ISSUED entry triggers an assertion and is ignored.
- Prefetch entries go through the same lifecycle. The flag is only carried to dequeue_prefetch; the consumer releases them without a core response.

## Timing
- All state is updated at posedge. All outputs are combinational from registered state, with zero-cycle request-to-output paths for pending/fill_addr.
- Simultaneous events, with all decisions made on pre-edge state:
  - Allocate and release in the same cycle: allocate cannot take the entry being released. The released entry is FREE next cycle.
  - Allocate and fill in the same cycle with allocate_addr == addr[fill_id]: the new entry goes directly to READY, so no lost wakeup.
  - Fill and dequeue fire in the same cycle: the dequeued entry (READY) goes to ISSUED. Entries woken by fill become dequeuable the next cycle.
  - Release and dequeue of different entries in the same cycle are both applied.
- Latencies:
  - allocate→dequeue: earliest is the cycle after the fill that wakes it.
  - fill→dequeue_valid: 1 cycle.
- count changes by +1 on allocate fire and −1 on a legal release, with net 0 when both happen. It never wraps: allocate is blocked at MSHR_SIZE and release at 0 is an assertion.
- Reset, including mid-operation, forces on the next edge:
  - all entries FREE;
  - count=0, almost_full=0 (if ALM_FULL_THRESH>0), dequeue_valid=0, allocate_ready=1, allocate_pending=0.
  - Payload/address arrays are not reset.

## Structure
- vx_mshr_pkg holds:
  - the entry state enum (FREE=2'd0, WAIT=2'd1, READY=2'd2, ISSUED=2'd3);
  - a helper function is_busy(state).
- Reuse the existing lowest-index priority encoder (VX_lzc) twice: for FREE selection and for READY selection.
- The payload array is flop-based, indexed by the dequeue selection.
- No other sub-modules.

## Test plan
- Reset, then allocate addr 0x10 ×3 → ids 0,1,2. allocate_pending = 0,1,1. count=3. dequeue_valid=0.
- fill_id=0 → next cycle entries 0–2 READY. Dequeue in order 0,1,2 with addr 0x10 and the stored data.
- Fill all 8 entries → allocate_ready=0, count=8, almost_full=1 at count 7. Release id 3 from ISSUED → the next allocate gets id 3.
- Same-cycle allocate 0x20 and fill of the entry holding 0x20 → the new entry is dequeued the following cycle without a second fill.
- Same-cycle release id 5 and allocate with only id 5 busy-adjacent free slots absent → allocate_ready stays 0 that cycle. Next cycle allocate gets 5.
- Assert reset with 4 ISSUED and 2 READY entries → next cycle count=0, dequeue_valid=0, allocate_id=0, allocate_ready=1.
